// File: rtl/ay_wait.sv
// Stretches Z80 I/O cycles in turbo modes so the PSG sees bdir/bc1 for HOLD_EDGES AY clock edges.
// Latency: wait_req rises 1 clk28 after the decoder asserts ay_cycle; wait_req is itself the CPU stall.
module ay_wait #(
  parameter int HOLD_EDGES = 2,
  parameter int RECOVERY   = 2,
  parameter int TIMEOUT    = 63
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] turbo,
  input  logic       ck35,
  input  logic       ay_clk,
  input  logic       ay_cycle,
  output logic       wait_req,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD    = 2'd1,
    S_RELEASE = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       ay_cycle_q, ay_clk_q;
  logic [3:0] ecnt_q, ecnt_d;
  logic [3:0] rcnt_q, rcnt_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       timeout_q, timeout_d;

  logic       rise, ay_edge;
  logic [4:0] ecnt_inc;
  logic [8:0] tcnt_inc;

  assign rise     = ay_cycle && !ay_cycle_q;
  assign ay_edge  = ay_clk && !ay_clk_q;
  assign ecnt_inc = {1'b0, ecnt_q} + {4'd0, ay_edge};
  assign tcnt_inc = {1'b0, tcnt_q} + 9'd1;

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ay_cycle_q <= 1'b0;
      ay_clk_q   <= 1'b0;
      ecnt_q     <= 4'd0;
      rcnt_q     <= 4'd0;
      tcnt_q     <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ay_cycle_q <= ay_cycle;
      ay_clk_q   <= ay_clk;
      ecnt_q     <= ecnt_d;
      rcnt_q     <= rcnt_d;
      tcnt_q     <= tcnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ecnt_d    = ecnt_q;
    rcnt_d    = rcnt_q;
    tcnt_d    = tcnt_q;
    timeout_d = 1'b0;
    if (!en) begin
      state_d = S_IDLE;
      ecnt_d  = 4'd0;
      rcnt_d  = 4'd0;
      tcnt_d  = 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // turbo is only looked at here; native timing needs no stretch
          if (rise && turbo != 2'd0) begin
            state_d = S_HOLD;
            ecnt_d  = 4'd0;
            tcnt_d  = 8'd0;
          end
        end
        S_HOLD: begin
          ecnt_d = ecnt_inc[3:0];
          tcnt_d = tcnt_inc[7:0];
          if (!ay_cycle) begin
            state_d = S_RECOVER;
            rcnt_d  = 4'd0;
          end else if (ecnt_inc >= 5'(HOLD_EDGES)) begin
            state_d = S_RELEASE;
          end else if (tcnt_inc >= 9'(TIMEOUT)) begin
            state_d   = S_RELEASE;
            timeout_d = 1'b1;
          end
        end
        S_RELEASE: begin
          if (!ay_cycle) begin
            state_d = S_RECOVER;
            rcnt_d  = 4'd0;
          end
        end
        S_RECOVER: begin
          if (rcnt_q >= 4'(RECOVERY)) begin
            if (ay_cycle) begin
              state_d = S_HOLD;
              ecnt_d  = 4'd0;
              tcnt_d  = 8'd0;
            end else begin
              state_d = S_IDLE;
            end
          end else if (ck35 && rcnt_q != 4'hF) begin
            rcnt_d = rcnt_q + 4'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A new access arriving during recovery must stall until the gap is honoured
  assign wait_req = (state_q == S_HOLD) || (state_q == S_RECOVER && ay_cycle);
  assign busy     = (state_q != S_IDLE);
  assign timeout  = timeout_q;

endmodule
